// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register pending-write counters for decode hazard stall.
// Ports:
//   clk, rst_n (async, active-low)
//   dec_valid, dec_rs/dec_rt (+ _used), dec_wr_en/dec_wr_sel : decode slot
//   retire_valid/retire_sel : writeback
//   clr  : synchronous flush of all pending state
//   stall, issue (comb), busy_vec, err (registered)
//   stall_cnt : only with ID_SCOREBOARD_STALL_CNT_EN defined
module id_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dec_valid,
  input  logic [SEL_W-1:0]    dec_rs,
  input  logic [SEL_W-1:0]    dec_rt,
  input  logic                dec_rs_used,
  input  logic                dec_rt_used,
  input  logic                dec_wr_en,
  input  logic [SEL_W-1:0]    dec_wr_sel,
  input  logic                retire_valid,
  input  logic [SEL_W-1:0]    retire_sel,
  input  logic                clr,
  output logic                stall,
  output logic                issue,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                err
`ifdef ID_SCOREBOARD_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                err_q, err_d;

  logic rs_hit, rt_hit, wr_full;

  // Selects beyond NUM_REGS never match a loop index, so they read as idle.
  always_comb begin
    rs_hit  = 1'b0;
    rt_hit  = 1'b0;
    wr_full = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (dec_rs == SEL_W'(i) && busy_q[i])
        rs_hit = 1'b1;
      if (dec_rt == SEL_W'(i) && busy_q[i])
        rt_hit = 1'b1;
      if (dec_wr_sel == SEL_W'(i) && cnt_q[i] == CNT_MAX)
        wr_full = 1'b1;
    end
  end

  assign stall = dec_valid &
                 ((dec_rs_used & rs_hit) |
                  (dec_rt_used & rt_hit) |
                  (dec_wr_en & wr_full));
  assign issue = dec_valid & ~stall & ~clr;

  always_comb begin
    logic inc, dec;
    err_d  = err_q;
    busy_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      inc = issue & dec_wr_en & (dec_wr_sel == SEL_W'(i));
      dec = retire_valid & (retire_sel == SEL_W'(i));
      cnt_d[i] = cnt_q[i];
      if (clr) begin
        cnt_d[i] = '0;
      end else if (inc && !dec) begin
        if (cnt_q[i] == CNT_MAX)
          err_d = 1'b1;
        else
          cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec && !inc) begin
        if (cnt_q[i] == '0)
          err_d = 1'b1;
        else
          cnt_d[i] = cnt_q[i] - 1'b1;
      end
      busy_d[i] = |cnt_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        cnt_q[i] <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        cnt_q[i] <= cnt_d[i];
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy_vec = busy_q;
  assign err      = err_q;

`ifdef ID_SCOREBOARD_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating; clr is a pipeline event and leaves the statistic alone.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else
      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: directed + random stimulus against a
// count-per-register reference model of id_scoreboard.
module tb_id_scoreboard;

  localparam int MAXC = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dec_valid, dec_rs_used, dec_rt_used, dec_wr_en;
  logic [2:0] dec_rs, dec_rt, dec_wr_sel, retire_sel;
  logic       retire_valid, clr;
  logic       stall, issue, err;
  logic [7:0] busy_vec;
`ifdef ID_SCOREBOARD_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  id_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid),
    .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used),
    .dec_wr_en(dec_wr_en), .dec_wr_sel(dec_wr_sel),
    .retire_valid(retire_valid), .retire_sel(retire_sel),
    .clr(clr),
    .stall(stall), .issue(issue),
    .busy_vec(busy_vec), .err(err)
`ifdef ID_SCOREBOARD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cnt [8];
  bit m_err;
  int m_sc;
  bit e_stall, e_issue;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  function automatic logic [7:0] m_busy();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = cnt[i] > 0;
    return b;
  endfunction

  function automatic void model_eval();
    e_stall = dec_valid &&
      ((dec_rs_used && cnt[dec_rs] > 0) ||
       (dec_rt_used && cnt[dec_rt] > 0) ||
       (dec_wr_en && cnt[dec_wr_sel] == MAXC));
    e_issue = dec_valid && !e_stall && !clr;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    m_err = 0;
    m_sc  = 0;
  endfunction

  function automatic void model_edge();
    if (e_stall && m_sc < 65535) m_sc++;
    if (clr) begin
      for (int i = 0; i < 8; i++) cnt[i] = 0;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      bit inc, dcr;
      inc = e_issue && dec_wr_en && dec_wr_sel == 3'(i);
      dcr = retire_valid && retire_sel == 3'(i);
      if (inc && !dcr) begin
        if (cnt[i] == MAXC) m_err = 1; else cnt[i]++;
      end else if (dcr && !inc) begin
        if (cnt[i] == 0) m_err = 1; else cnt[i]--;
      end
    end
  endfunction

  // Called with inputs already driven just after a falling edge.
  task automatic step();
    #1;
    model_eval();
    chk("stall", 32'(stall), 32'(e_stall));
    chk("issue", 32'(issue), 32'(e_issue));
    chk("busy_vec", 32'(busy_vec), 32'(m_busy()));
    chk("err", 32'(err), 32'(m_err));
`ifdef ID_SCOREBOARD_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_sc));
`endif
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic drv(int v, int rs, int rsu, int rt, int rtu,
                     int we, int ws, int rv, int rsl, int c);
    dec_valid    = v[0];
    dec_rs       = 3'(rs);
    dec_rs_used  = rsu[0];
    dec_rt       = 3'(rt);
    dec_rt_used  = rtu[0];
    dec_wr_en    = we[0];
    dec_wr_sel   = 3'(ws);
    retire_valid = rv[0];
    retire_sel   = 3'(rsl);
    clr          = c[0];
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_in();
    int pend [$];
    int v, we, ws, rv, rsl, c;
    v  = ($urandom % 4) != 0;
    we = $urandom % 2;
    ws = $urandom % 8;
    c  = ($urandom % 64) == 0;
    rv = $urandom % 2;
    for (int i = 0; i < 8; i++) if (cnt[i] > 0) pend.push_back(i);
    if (pend.size() > 0 && ($urandom % 8) != 0)
      rsl = pend[$urandom % pend.size()];
    else
      rsl = $urandom % 8;
    if (c) rv = 0;
    if (rv && cnt[rsl] == 0 && we && ws == rsl) rv = 0;
    drv(v, $urandom % 8, $urandom % 2, $urandom % 8, $urandom % 2,
        we, ws, rv, rsl, c);
  endtask

  initial begin
    model_reset();
    idle();
    @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy_vec), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    drv(1, 3, 1, 0, 0, 1, 3, 0, 0, 0);
    #1;
    chk("rst_issue", 32'(issue), 32'h1);
    @(negedge clk);
    chk("rst_hold_busy", 32'(busy_vec), 32'h0);
    idle();
    rst_n = 1'b1;
    step();

    // write r3, then read r3 until retire is visible
    drv(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    #1 chk("w3_issue", 32'(issue), 32'h1);
    step();
    drv(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("raw_stall", 32'(stall), 32'h1);
    chk("busy3", 32'(busy_vec), 32'h08);
    step();
    drv(1, 3, 1, 0, 0, 0, 0, 1, 3, 0);
    #1 chk("ret_same_stall", 32'(stall), 32'h1);
    chk("ret_same_issue", 32'(issue), 32'h0);
    step();
    drv(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("after_ret_issue", 32'(issue), 32'h1);
    chk("after_ret_busy", 32'(busy_vec), 32'h0);
    step();

    // saturate r2 writes
    repeat (3) begin
      drv(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
      step();
    end
    drv(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    #1 chk("full_stall", 32'(stall), 32'h1);
    chk("full_busy", 32'(busy_vec), 32'h04);
    step();
    drv(1, 0, 0, 0, 0, 1, 2, 1, 2, 0);
    #1 chk("full_ret_stall", 32'(stall), 32'h1);
    step();
    drv(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    #1 chk("fourth_issue", 32'(issue), 32'h1);
    step();
    repeat (3) begin
      drv(0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
      step();
    end
    idle();
    #1 chk("r2_drained", 32'(busy_vec), 32'h0);
    step();

    // issue+retire r1 same cycle, then underflow r4
    drv(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    step();
    drv(1, 0, 0, 0, 0, 1, 1, 1, 1, 0);
    #1 chk("iss_ret_issue", 32'(issue), 32'h1);
    step();
    idle();
    #1 chk("iss_ret_busy", 32'(busy_vec), 32'h02);
    chk("no_err_yet", 32'(err), 32'h0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
    step();
    idle();
    #1 chk("underflow_err", 32'(err), 32'h1);
    step();
    step();
    #1 chk("err_sticky", 32'(err), 32'h1);

    // clr with pending r0, r7
    drv(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step();
    drv(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    step();
    drv(1, 0, 0, 0, 0, 1, 3, 0, 0, 1);
    #1 chk("clr_busy_before", 32'(busy_vec), 32'h83);
    chk("clr_issue", 32'(issue), 32'h0);
    step();
    idle();
    #1 chk("clr_busy_after", 32'(busy_vec), 32'h0);
    chk("clr_err_kept", 32'(err), 32'h1);
    step();

    // randomized run with one mid-stream reset pulse
    for (int k = 0; k < 3000; k++) begin
      rand_in();
      if (k == 1500) begin
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy_vec), 32'h0);
        chk("mid_rst_err", 32'(err), 32'h0);
        model_reset();
      end
      step();
      rst_n = 1'b1;
    end

`ifdef ID_SCOREBOARD_STALL_CNT_EN
    idle();
    rst_n = 1'b0;
    model_reset();
    step();
    rst_n = 1'b1;
    drv(1, 0, 0, 0, 0, 1, 6, 0, 0, 0);
    step();
    drv(1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (10) step();
    #1 chk("sc_ten", 32'(stall_cnt), 32'd10);
    drv(1, 6, 1, 0, 0, 0, 0, 0, 0, 1);
    step();
    drv(1, 6, 1, 0, 0, 1, 6, 0, 0, 0);
    step();
    drv(1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (70000) step();
    #1 chk("sc_sat", 32'(stall_cnt), 32'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
